// File: rtl/serial_nibble_adder_if.sv
// serial_nibble_adder_if: start/done handshake plus operand and result bus
// for serial_nibble_adder. Optional macro SERIAL_ADDER_SUB_EN adds the
// subtract-select line.
interface serial_nibble_adder_if #(
  parameter int NIBBLES = 4
) ();
  logic                 start;
  logic [4*NIBBLES-1:0] a;
  logic [4*NIBBLES-1:0] b;
  logic                 cin;
  logic                 busy;
  logic                 done;
  logic [4*NIBBLES-1:0] sum;
  logic                 cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic                 sub;
`endif

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_nibble_adder.sv
// serial_nibble_adder: computes a + b + cin over 4*NIBBLES bits, one nibble
// per clock through a single 4-bit ripple add, LSB nibble first.
// Optional macro SERIAL_ADDER_SUB_EN: adds a sub select that stores B
// inverted and forces the initial carry to 1 (a - b, cout=1 means no borrow).
module serial_nibble_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_nibble_adder_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  a_r, b_r, res_r, sum_r;
  logic          carry, cout_r, busy_r, done_r;
  logic [IW-1:0] idx;

  logic [3:0]    a_nib, b_nib;
  logic [4:0]    nib_sum;
  logic [W-1:0]  res_nxt;
  logic [W-1:0]  b_load;
  logic          c_load;

  // Operand conditioning at capture time (inversion only in the subtract build).
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load = bus.sub ? ~bus.b : bus.b;
    c_load = bus.sub ? 1'b1 : bus.cin;
`else
    b_load = bus.b;
    c_load = bus.cin;
`endif
  end

  // Select nibble idx, add it with the running carry, and splice the result back.
  always_comb begin
    a_nib   = '0;
    b_nib   = '0;
    res_nxt = res_r;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_r[4*i +: 4];
        b_nib = b_r[4*i +: 4];
      end
    end
    nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) res_nxt[4*i +: 4] = nib_sum[3:0];
    end
  end

  // Sequencer: accept, step one nibble per edge, publish the full result on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      res_r  <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= b_load;
            carry  <= c_load;
            idx    <= '0;
            state  <= RUN;
            busy_r <= 1'b1;
            done_r <= 1'b0;
          end else begin
            state  <= IDLE;
            done_r <= 1'b0;
          end
        end
        RUN: begin
          res_r <= res_nxt;
          carry <= nib_sum[4];
          if (idx == LAST) begin
            sum_r  <= res_nxt;
            cout_r <= nib_sum[4];
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_nibble_adder.sv
// tb_serial_nibble_adder: directed tests for serial_nibble_adder at NIBBLES=4
// and NIBBLES=1. Define SERIAL_ADDER_SUB_EN to include the subtract tests.
module tb_serial_nibble_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_nibble_adder_if #(.NIBBLES(4)) bus4 ();
  serial_nibble_adder_if #(.NIBBLES(1)) bus1 ();

  serial_nibble_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  serial_nibble_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request to the 4-nibble DUT for exactly one edge (E0).
  task automatic issue4(input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
  endtask

  // Steps until done is seen; lat is edges after E0, or -1 if the bound expires.
  task automatic wait_done4(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus4.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (bus4.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus4.busy); end
    checks++; if (bus4.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus4.done); end
    checks++; if (bus4.sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h want=0000", bus4.sum); end
    checks++; if (bus4.cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b want=0", bus4.cout); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    issue4(16'h0001, 16'h0001, 1'b0);
    checks++; if (bus4.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_e0 got=%b want=1", bus4.busy); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin failures++; $display("FAIL basic_run_e%0d busy=%b done=%b want busy=1 done=0", i, bus4.busy, bus4.done); end
      checks++; if (bus4.sum !== 16'h0000) begin failures++; $display("FAIL basic_partial_e%0d got=%h want=0000", i, bus4.sum); end
    end
    step();
    checks++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b1) begin failures++; $display("FAIL basic_e4 busy=%b done=%b want busy=0 done=1", bus4.busy, bus4.done); end
    checks++; if (bus4.sum !== 16'h0002 || bus4.cout !== 1'b0) begin failures++; $display("FAIL basic_result got=%h/%b want=0002/0", bus4.sum, bus4.cout); end
    step();
    checks++; if (bus4.done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b want=0", bus4.done); end
    checks++; if (bus4.sum !== 16'h0002) begin failures++; $display("FAIL basic_hold got=%h want=0002", bus4.sum); end
  endtask

  task automatic test_carry_ripple();
    int lat;
    issue4(16'hFFFF, 16'h0000, 1'b1);
    wait_done4(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL ripple_latency got=%0d want=4", lat); end
    checks++; if (bus4.sum !== 16'h0000 || bus4.cout !== 1'b1) begin failures++; $display("FAIL ripple_result got=%h/%b want=0000/1", bus4.sum, bus4.cout); end
    step();
  endtask

  task automatic test_start_ignored();
    int pulses = 0;
    logic [15:0] seen = '0;
    issue4(16'h1234, 16'h4321, 1'b0);
    step();
    bus4.a = 16'hFFFF; bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus4.done === 1'b1) begin pulses++; seen = bus4.sum; end
      step();
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL ignore_pulses got=%0d want=1", pulses); end
    checks++; if (seen !== 16'h5555) begin failures++; $display("FAIL ignore_sum got=%h want=5555", seen); end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    issue4(16'h00FF, 16'h0001, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin failures++; $display("FAIL abort_flags busy=%b done=%b want 0/0", bus4.busy, bus4.done); end
    checks++; if (bus4.sum !== 16'h0000 || bus4.cout !== 1'b0) begin failures++; $display("FAIL abort_result got=%h/%b want=0000/0", bus4.sum, bus4.cout); end
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus4.done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_done got=%0d pulses want=0", pulses); end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue4(16'h0001, 16'h0001, 1'b0);
    wait_done4(lat);
    checks++; if (lat !== 4 || bus4.sum !== 16'h0002) begin failures++; $display("FAIL b2b_first lat=%0d sum=%h want 4/0002", lat, bus4.sum); end
    issue4(16'hABCD, 16'h1111, 1'b1);
    checks++; if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin failures++; $display("FAIL b2b_accept busy=%b done=%b want 1/0", bus4.busy, bus4.done); end
    checks++; if (bus4.sum !== 16'h0002) begin failures++; $display("FAIL b2b_hold got=%h want=0002", bus4.sum); end
    wait_done4(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_latency got=%0d want=4", lat); end
    checks++; if (bus4.sum !== 16'hBCDF || bus4.cout !== 1'b0) begin failures++; $display("FAIL b2b_result got=%h/%b want=BCDF/0", bus4.sum, bus4.cout); end
    step();
  endtask

  task automatic test_single_nibble();
    int lat = -1;
    bus1.a = 4'hF; bus1.b = 4'h1; bus1.cin = 1'b0; bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    checks++; if (bus1.busy !== 1'b1) begin failures++; $display("FAIL n1_busy got=%b want=1", bus1.busy); end
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus1.done === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat !== 1) begin failures++; $display("FAIL n1_latency got=%0d want=1", lat); end
    checks++; if (bus1.sum !== 4'h0 || bus1.cout !== 1'b1) begin failures++; $display("FAIL n1_result got=%h/%b want=0/1", bus1.sum, bus1.cout); end
    step();
    checks++; if (bus1.done !== 1'b0) begin failures++; $display("FAIL n1_done_pulse got=%b want=0", bus1.done); end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    bus4.sub = 1'b1;
    issue4(16'h0005, 16'h0007, 1'b0);
    wait_done4(lat);
    checks++; if (lat !== 4 || bus4.sum !== 16'hFFFE || bus4.cout !== 1'b0) begin failures++; $display("FAIL sub_borrow lat=%0d got=%h/%b want=4 FFFE/0", lat, bus4.sum, bus4.cout); end
    step();
    issue4(16'h0007, 16'h0005, 1'b0);
    wait_done4(lat);
    checks++; if (lat !== 4 || bus4.sum !== 16'h0002 || bus4.cout !== 1'b1) begin failures++; $display("FAIL sub_noborrow lat=%0d got=%h/%b want=4 0002/1", lat, bus4.sum, bus4.cout); end
    bus4.sub = 1'b0;
    step();
  endtask
`endif

  initial begin
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus4.sub = 1'b0;
    bus1.sub = 1'b0;
`endif
    #1;
    test_reset();
    test_basic();
    test_carry_ripple();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_single_nibble();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
